cmd_stream_tx: RTL

Command byte-stream transmitter that drives the pipeline's command input and collects its single-byte reply. It takes one structured command (opcode, payload, expect-response flag) and serializes it into the byte stream consumed by the pipeline head's command receiver, then optionally waits for the response byte. It is used for the on-chip boot/test sequencer and the simulation command driver.

---
 rtl/cmd_stream_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/cmd_stream_tx.sv
// cmd_stream_tx: serializes one structured command into a byte stream
// and optionally waits for a single response byte.
module cmd_stream_tx #(
    parameter int MAX_PAYLOAD    = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int LEN_W          = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_opcode,
    input  logic [LEN_W-1:0]         req_len,
    input  logic [8*MAX_PAYLOAD-1:0] req_payload,
    input  logic                     req_expect_rsp,
    output logic                     cmd_m_valid,
    input  logic                     cmd_m_ready,
    output logic [7:0]               cmd_m_data,
    input  logic                     rsp_s_valid,
    output logic                     rsp_s_ready,
    input  logic [7:0]               rsp_s_data,
    output logic                     done,
    output logic                     done_timeout,
    output logic [7:0]               done_rsp,
    output logic [7:0]               stray_count
);

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_OP,
        SEND_PAYLOAD,
        WAIT_RSP,
        DONE
    } state_t;

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LIM =
        TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t                     r_state;
    state_t                     w_next;
    byte_t                      r_opcode;
    logic [8*MAX_PAYLOAD-1:0]   r_payload;
    logic [LEN_W-1:0]           r_len;
    logic                       r_expect;
    logic [LEN_W-1:0]           r_idx;
    logic [TO_W-1:0]            r_tcnt;
    byte_t                      r_done_rsp;
    logic                       r_done_to;
    byte_t                      r_stray;

    byte_t                      w_pay_byte;
    logic                       w_sending;
    logic                       w_byte_acc;
    logic                       w_last_byte;
    logic                       w_rsp_hit;
    logic                       w_timeout;
    logic                       w_enter_wait;
    logic                       w_enter_done;

    assign w_sending   = (r_state == SEND_OP) || (r_state == SEND_PAYLOAD);
    assign w_byte_acc  = w_sending && cmd_m_ready;
    assign w_last_byte = ((r_state == SEND_OP) && (r_len == '0)) ||
                         ((r_state == SEND_PAYLOAD) &&
                          (r_idx == r_len - LEN_W'(1)));
    assign w_rsp_hit   = (r_state == WAIT_RSP) && rsp_s_valid;
    assign w_timeout   = TO_EN && (r_state == WAIT_RSP) && !rsp_s_valid &&
                         (r_tcnt == TO_LIM);
    assign w_enter_wait = (w_next == WAIT_RSP) && (r_state != WAIT_RSP);
    assign w_enter_done = (w_next == DONE) && (r_state != DONE);

    assign rsp_s_ready  = 1'b1;
    assign done_timeout = r_done_to;
    assign done_rsp     = r_done_rsp;
    assign stray_count  = r_stray;

    // Select the payload byte addressed by the send index.
    always_comb begin
        w_pay_byte = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (r_idx == LEN_W'(i)) begin
                w_pay_byte = r_payload[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = SEND_OP;
                end
            end
            SEND_OP, SEND_PAYLOAD: begin
                if (w_byte_acc) begin
                    if (w_last_byte) begin
                        w_next = r_expect ? WAIT_RSP : DONE;
                    end else begin
                        w_next = SEND_PAYLOAD;
                    end
                end
            end
            WAIT_RSP: begin
                if (w_rsp_hit || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        req_ready   = 1'b0;
        cmd_m_valid = 1'b0;
        cmd_m_data  = 8'h00;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = rstn;
            end
            SEND_OP: begin
                cmd_m_valid = 1'b1;
                cmd_m_data  = r_opcode;
            end
            SEND_PAYLOAD: begin
                cmd_m_valid = 1'b1;
                cmd_m_data  = w_pay_byte;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Capture the request at acceptance and step the payload index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_opcode  <= '0;
            r_payload <= '0;
            r_len     <= '0;
            r_expect  <= 1'b0;
            r_idx     <= '0;
        end else if ((r_state == IDLE) && req_valid) begin
            r_opcode  <= req_opcode;
            r_payload <= req_payload;
            r_len     <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
            r_expect  <= req_expect_rsp;
            r_idx     <= '0;
        end else if ((r_state == SEND_PAYLOAD) && w_byte_acc &&
                     !w_last_byte) begin
            r_idx <= r_idx + LEN_W'(1);
        end
    end

    // Response wait counter, cleared on entry to WAIT_RSP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tcnt <= '0;
        end else if (w_enter_wait) begin
            r_tcnt <= '0;
        end else if (r_state == WAIT_RSP) begin
            r_tcnt <= r_tcnt + TO_W'(1);
        end
    end

    // Completion result, updated once per command and held until the next.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done_rsp <= '0;
            r_done_to  <= 1'b0;
        end else if (w_enter_done) begin
            if (w_rsp_hit) begin
                r_done_rsp <= rsp_s_data;
                r_done_to  <= 1'b0;
            end else if (w_timeout) begin
                r_done_rsp <= '0;
                r_done_to  <= 1'b1;
            end else begin
                r_done_rsp <= '0;
                r_done_to  <= 1'b0;
            end
        end
    end

    // Saturating count of response bytes that arrive with nobody waiting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stray <= '0;
        end else if (rsp_s_valid && (r_state != WAIT_RSP) &&
                     (r_stray != 8'hFF)) begin
            r_stray <= r_stray + 8'd1;
        end
    end

endmodule
